// File: rtl/handshake_pkg.sv
// Shared types and helpers for the handshake constant burst unit.
// FSM state encoding and the counter width rule.
package handshake_pkg;

  typedef enum logic {
    IDLE = 1'b0,
    EMIT = 1'b1
  } state_t;

  function automatic int cnt_width(input int n);
    int w;
    w = $clog2(n + 1);
    return (w > 1) ? w : 1;
  endfunction

endpackage

// File: rtl/handshake_constant_burst.sv
// Emits REPEAT registered VALUE tokens per accepted ctrl token.
// Last-token cycle can accept a new ctrl token without a bubble.
module handshake_constant_burst
  import handshake_pkg::*;
#(
  parameter int          DATA_WIDTH = 32,
  parameter logic [63:0] VALUE      = 64'd0,
  parameter int          REPEAT     = 1
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  ctrl_valid,
  output logic                  ctrl_ready,
  output logic [DATA_WIDTH-1:0] outs,
  output logic                  outs_valid,
  input  logic                  outs_ready,
  output logic                  outs_last,
  output logic                  busy
);

  localparam int CNT_WIDTH = cnt_width(REPEAT);
  localparam logic [DATA_WIDTH-1:0] VAL =
    DATA_WIDTH'(VALUE);
  localparam logic [CNT_WIDTH-1:0] REP =
    CNT_WIDTH'(REPEAT);
  localparam logic LAST1 = (REPEAT == 1);

  state_t               state;
  logic [CNT_WIDTH-1:0] remaining;
  logic                 out_fire;
  logic                 ctrl_fire;

  assign out_fire   = outs_valid & outs_ready;
  // outs_last is only ever high in EMIT on the final token
  assign ctrl_ready = (state == IDLE)
                    | (outs_last & outs_ready);
  assign ctrl_fire  = ctrl_valid & ctrl_ready;
  assign busy       = (state == EMIT);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state      <= IDLE;
      remaining  <= '0;
      outs_valid <= 1'b0;
      outs       <= '0;
      outs_last  <= 1'b0;
    end else begin
      unique case (state)
        IDLE: begin
          if (ctrl_fire) begin
            state      <= EMIT;
            remaining  <= REP;
            outs_valid <= 1'b1;
            outs       <= VAL;
            outs_last  <= LAST1;
          end
        end
        EMIT: begin
          if (out_fire) begin
            if (remaining == CNT_WIDTH'(1)) begin
              if (ctrl_fire) begin
                remaining  <= REP;
                outs_valid <= 1'b1;
                outs       <= VAL;
                outs_last  <= LAST1;
              end else begin
                state      <= IDLE;
                remaining  <= '0;
                outs_valid <= 1'b0;
                outs       <= '0;
                outs_last  <= 1'b0;
              end
            end else begin
              remaining <= remaining - CNT_WIDTH'(1);
              outs_last <= (remaining == CNT_WIDTH'(2));
            end
          end
        end
      endcase
    end
  end

endmodule

// File: tb/tb_handshake_constant_burst.sv
// Scoreboard bench: five configurations, directed then random traffic.
// Expected tokens are queued on ctrl acceptance and popped on out fire.
module tb_handshake_constant_burst;

  localparam int N = 5;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rstn [N];
  logic cv   [N];
  logic ordy [N];
  logic cr_a [N];
  logic ov_a [N];
  logic bz_a [N];
  int   n_fire [N];
  int   qsz    [N];

  int tests = 0;
  int fails = 0;

  function automatic int dw_of(input int i);
    return (i == 0) ? 16 : 32;
  endfunction

  function automatic int rep_of(input int i);
    case (i)
      0: return 1;
      1: return 4;
      2: return 3;
      3: return 2;
      default: return 5;
    endcase
  endfunction

  function automatic logic [63:0] val_of(input int i);
    case (i)
      0: return 64'h2A;
      1: return 64'hDEADBEEF;
      2: return 64'hFFFF_0000_1234_5678;
      3: return 64'h5A;
      default: return 64'hA5C3;
    endcase
  endfunction

  function automatic void chk(input string nm, input int idx,
                              input logic [63:0] act,
                              input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s[%0d]: got %0h, want %0h",
               nm, idx, act, exp);
    end
  endfunction

  for (genvar g = 0; g < N; g++) begin : blk
    localparam int DW = dw_of(g);
    localparam int RP = rep_of(g);
    localparam logic [63:0] V = val_of(g);
    localparam logic [31:0] EV =
      32'(V & ((64'd1 << DW) - 64'd1));

    logic          cr, ov, ol, bz;
    logic [DW-1:0] od;
    logic [32:0]   q [$];

    handshake_constant_burst #(
      .DATA_WIDTH(DW),
      .VALUE(V),
      .REPEAT(RP)
    ) dut (
      .clk(clk),
      .rst(rstn[g]),
      .ctrl_valid(cv[g]),
      .ctrl_ready(cr),
      .outs(od),
      .outs_valid(ov),
      .outs_ready(ordy[g]),
      .outs_last(ol),
      .busy(bz)
    );

    assign cr_a[g] = cr;
    assign ov_a[g] = ov;
    assign bz_a[g] = bz;

    initial begin : mon
      logic ev, ecr;
      n_fire[g] = 0;
      qsz[g] = 0;
      forever begin
        @(negedge clk);
        if (!rstn[g]) begin
          q.delete();
          chk("rst_valid", g, 64'(ov), 64'd0);
          chk("rst_outs", g, 64'(od), 64'd0);
          chk("rst_last", g, 64'(ol), 64'd0);
          chk("rst_busy", g, 64'(bz), 64'd0);
          chk("rst_ready", g, 64'(cr), 64'd1);
        end else begin
          ev  = (q.size() != 0);
          ecr = !ev || (q.size() == 1 && ordy[g]);
          chk("valid", g, 64'(ov), 64'(ev));
          chk("busy", g, 64'(bz), 64'(ev));
          chk("ctrl_ready", g, 64'(cr), 64'(ecr));
          if (ov && ev) begin
            chk("outs", g, 64'(od), 64'(EV));
            chk("last", g, 64'(ol), 64'(q[0][32]));
          end else if (!ov) begin
            chk("idle_outs", g, 64'(od), 64'd0);
            chk("idle_last", g, 64'(ol), 64'd0);
          end
          if (ov && ordy[g]) begin
            n_fire[g]++;
            if (ev) void'(q.pop_front());
          end
          if (cv[g] && ecr)
            for (int k = 0; k < RP; k++)
              q.push_back({k == RP - 1, EV});
        end
        qsz[g] = q.size();
      end
    end
  end

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout, want finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int pat [6];
    pat = '{1, 0, 0, 1, 0, 1};
    for (int i = 0; i < N; i++) begin
      rstn[i] = 1'b0;
      cv[i]   = 1'b0;
      ordy[i] = 1'b1;
    end
    step(3);
    for (int i = 0; i < N; i++) rstn[i] = 1'b1;
    step(4);
    for (int i = 0; i < N; i++)
      chk("idle_fires", i, 64'(n_fire[i]), 64'd0);

    // REPEAT=1 streaming
    cv[0] = 1'b1;
    step(10);
    cv[0] = 1'b0;
    step(3);
    chk("a_fires", 0, 64'(n_fire[0]), 64'd10);

    // REPEAT=4 single burst
    cv[1] = 1'b1;
    step(1);
    cv[1] = 1'b0;
    step(6);
    chk("b_fires", 1, 64'(n_fire[1]), 64'd4);

    // REPEAT=3 with stalls
    ordy[2] = 1'b0;
    cv[2] = 1'b1;
    step(1);
    cv[2] = 1'b0;
    for (int k = 0; k < 6; k++) begin
      ordy[2] = pat[k][0];
      step(1);
    end
    chk("c_fires", 2, 64'(n_fire[2]), 64'd3);
    chk("c_drained", 2, 64'(qsz[2]), 64'd0);
    ordy[2] = 1'b1;
    step(2);

    // REPEAT=2 back-to-back
    cv[3] = 1'b1;
    step(1);
    cv[3] = 1'b0;
    step(1);
    cv[3] = 1'b1;
    chk("d_reaccept", 3, 64'(cr_a[3]), 64'd1);
    step(1);
    cv[3] = 1'b0;
    step(3);
    chk("d_fires", 3, 64'(n_fire[3]), 64'd4);

    // REPEAT=5 reset mid-burst
    cv[4] = 1'b1;
    step(1);
    cv[4] = 1'b0;
    step(2);
    chk("e_pre_fires", 4, 64'(n_fire[4]), 64'd2);
    #2 rstn[4] = 1'b0;
    #1;
    chk("e_async_valid", 4, 64'(ov_a[4]), 64'd0);
    chk("e_async_busy", 4, 64'(bz_a[4]), 64'd0);
    chk("e_async_ready", 4, 64'(cr_a[4]), 64'd1);
    step(2);
    rstn[4] = 1'b1;
    step(4);
    chk("e_post_rst", 4, 64'(n_fire[4]), 64'd2);
    cv[4] = 1'b1;
    step(1);
    cv[4] = 1'b0;
    step(7);
    chk("e_fires", 4, 64'(n_fire[4]), 64'd7);

    // random traffic on every configuration
    for (int c = 0; c < 300; c++) begin
      for (int i = 0; i < N; i++) begin
        cv[i]   = 1'($urandom_range(0, 1));
        ordy[i] = ($urandom_range(0, 3) != 0);
      end
      step(1);
    end
    for (int i = 0; i < N; i++) begin
      cv[i]   = 1'b0;
      ordy[i] = 1'b1;
    end
    step(15);
    for (int i = 0; i < N; i++) begin
      chk("drained", i, 64'(qsz[i]), 64'd0);
      chk("end_idle", i, 64'(ov_a[i]), 64'd0);
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/handshake_constant_burst.md
Name: handshake_constant_burst

Overview:
- Parametrised successor to the dataflow constant unit: emits DATA_WIDTH-bit constant VALUE tokens under valid/ready handshake.
- Each accepted ctrl token produces REPEAT output tokens.
- outs and outs_valid are registered, so no combinational path runs from ctrl_valid to outs_valid.
- Sits in generated dataflow circuits wherever a constant feeds loops, or a decoupled (buffered) constant is needed.

Parameters:
- DATA_WIDTH, 32, output token width in bits.
- VALUE, 0, constant emitted; truncated or zero-extended to DATA_WIDTH.
- REPEAT, 1, tokens emitted per ctrl token; must be >= 1.
- CNT_WIDTH, localparam = max(1, clog2(REPEAT+1)), width of the remaining-token counter.

Ports:
- clk  input  1  clock, rising edge.
- rst  input  1  asynchronous, active-low reset; rst=0 resets the block.
- ctrl_valid  input  1  ctrl token offered.
- ctrl_ready  output  1  ctrl token accepted when high with ctrl_valid.
- outs  output  DATA_WIDTH  token data, registered.
- outs_valid  output  1  output token valid, registered.
- outs_ready  input  1  downstream accepts token.
- outs_last  output  1  high with outs_valid on the final token of a burst.
- busy  output  1  high while a burst is outstanding (state EMIT).

Behaviour:
- Reset (rst=0, asynchronous assert, synchronous release):
  - state=IDLE, remaining=0;
  - outs_valid=0, outs=0, outs_last=0, busy=0.
- Handshake events:
  - ctrl fire = ctrl_valid & ctrl_ready.
  - out fire = outs_valid & outs_ready.
- States: IDLE, EMIT.
- IDLE:
  - ctrl_ready=1, outs_valid=0.
  - On ctrl fire, next cycle: state=EMIT, remaining=REPEAT, outs_valid=1, outs=VALUE, outs_last=(REPEAT==1).
  - Latency from ctrl fire to outs_valid is exactly 1 cycle.
- EMIT:
  - outs_valid=1, outs=VALUE.
  - outs_last = (remaining==1).
- EMIT, out fire with remaining>1: remaining decrements by 1; stay in EMIT.
- EMIT, out fire with remaining==1 (last token):
  - ctrl_ready = outs_ready in this cycle (combinational), allowing back-to-back bursts.
  - If ctrl fires in the same cycle: stay in EMIT, reload remaining=REPEAT, outs_valid stays 1. No bubble, so REPEAT=1 sustains 1 token per cycle.
  - Otherwise: go to IDLE next cycle; outs_valid=0, outs=0, outs_last=0.
- EMIT, no out fire: every registered output holds; ctrl_ready=0.
- Output data: outs must be VALUE whenever outs_valid=1, and 0 whenever outs_valid=0.
- Stability: once outs_valid rises, it must not fall until out fire (AXI-style stable valid).
- ctrl_ready in IDLE must not depend on ctrl_valid.
- Reset asserted mid-burst: remaining tokens are discarded immediately and outputs return to reset values asynchronously. No tokens are emitted after release until a new ctrl fire.
- Counter: remaining never underflows and never wraps. It ranges 0..REPEAT and equals 0 only in IDLE.
- busy = (state==EMIT).

Decomposition:
- Shared package handshake_pkg:
  - state enum (IDLE, EMIT);
  - clog2-based width helper function.
- No sub-module. The counter and FSM are small enough to live inline.

Test Plan:
- Reset then idle: rst low 3 cycles, then high with ctrl_valid=0 -> outs_valid=0, outs=0, ctrl_ready=1, busy=0 throughout.
- REPEAT=1, VALUE=16'h002A, DATA_WIDTH=16, ctrl_valid and outs_ready held high 10 cycles -> first outs_valid 1 cycle after first ctrl fire; 10 tokens of 16'h002A on consecutive cycles; outs_last=1 on each; no bubbles.
- REPEAT=4, VALUE=32'hDEADBEEF, one ctrl token, outs_ready=1 -> exactly 4 tokens on 4 consecutive cycles; outs_last only on the 4th; ctrl_ready=0 during tokens 1-3; return to IDLE after.
- REPEAT=3, outs_ready toggling 1,0,0,1,0,1 -> outs and outs_valid stable during stalls; exactly 3 fires; outs_last held high across stalls on the final token.
- REPEAT=2, ctrl_valid re-offered during the last-token cycle with outs_ready=1 -> new ctrl accepted that cycle; outs_valid never drops; 4 tokens total in 4 cycles.
- REPEAT=5, rst pulsed low after 2 fires -> outs_valid=0 asynchronously, busy=0; after release no tokens until the next ctrl fire, which yields a fresh burst of 5.
